// File: rtl/idft_out_capture_if.sv
// ============================================================================
//  Module      : idft_out_capture_if
//  Description : Bundle between the IDFT core / register front-end and the
//                output capture buffer. The master side drives the core
//                outputs and register-block requests. The slave side is the
//                capture buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface idft_out_capture_if #(
    parameter int DW    = 16,
    parameter int BEATS = 32
) ();
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic              next_out_i;
    logic [DW-1:0]     y0_i;
    logic [DW-1:0]     y1_i;
    logic [DW-1:0]     y2_i;
    logic [DW-1:0]     y3_i;
    logic              clear_i;
    logic              rd_en_i;
    logic [IW-1:0]     rd_idx_i;
    logic [4*DW-1:0]   rd_data_o;
    logic              done_o;
    logic              busy_o;
    logic              overrun_o;

    modport master (
        output next_out_i, y0_i, y1_i, y2_i, y3_i, clear_i, rd_en_i, rd_idx_i,
        input  rd_data_o, done_o, busy_o, overrun_o
    );

    modport slave (
        input  next_out_i, y0_i, y1_i, y2_i, y3_i, clear_i, rd_en_i, rd_idx_i,
        output rd_data_o, done_o, busy_o, overrun_o
    );
endinterface

`default_nettype wire

// File: rtl/idft_out_capture.sv
// ============================================================================
//  Module      : idft_out_capture
//  Description : Captures the BEATS output beats of one IDFT transform into a
//                BEATS x 4*DW buffer after each next_out strobe. It also keeps
//                sticky done/overrun flags and serves indexed 1-cycle reads.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idft_out_capture #(
    parameter int DW    = 16,
    parameter int BEATS = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    idft_out_capture_if.slave    bus
);
    localparam int IW = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [0:0]    c_IDLE    = 1'b0;
    localparam logic [0:0]    c_CAPTURE = 1'b1;
    localparam logic [IW-1:0] c_LAST    = IW'(BEATS - 1);

    logic [0:0]      r_state;
    logic [IW-1:0]   r_cnt;
    logic            r_done;
    logic            r_overrun;
    logic [4*DW-1:0] r_rd_data;
    logic [4*DW-1:0] r_mem [BEATS];

    logic w_capture;
    logic w_last;
    logic w_start;

    assign w_capture = (r_state == c_CAPTURE);
    assign w_last    = w_capture && (r_cnt == c_LAST);
    // A strobe on the final beat starts the next transform without a gap.
    // Any other strobe during a capture only raises the overrun flag.
    assign w_start   = bus.next_out_i && (!w_capture || w_last);

    // Sequencing, beat counter and sticky status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (bus.clear_i) begin
                r_done    <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_capture) begin
                r_cnt <= r_cnt + 1'b1;
                if (bus.next_out_i && !w_last) begin
                    r_overrun <= 1'b1;
                end
            end
            // Completion is assigned after clear so it wins a same-cycle clear
            if (w_last) begin
                r_done  <= 1'b1;
                r_state <= c_IDLE;
            end
            if (w_start) begin
                r_state <= c_CAPTURE;
                r_cnt   <= '0;
                if (!w_capture) begin
                    r_done <= 1'b0;
                end
            end
        end
    end

    // Beat storage; the array is deliberately not reset
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_capture) begin
            r_mem[r_cnt] <= {bus.y3_i, bus.y2_i, bus.y1_i, bus.y0_i};
        end
    end

    // Registered read port; same-index write returns the old contents
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (bus.rd_en_i) begin
            r_rd_data <= r_mem[bus.rd_idx_i];
        end
    end

    assign bus.rd_data_o = r_rd_data;
    assign bus.done_o    = r_done;
    assign bus.busy_o    = w_capture;
    assign bus.overrun_o = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_idft_out_capture.sv
// ============================================================================
//  Module      : tb_idft_out_capture
//  Description : Directed scoreboard bench for idft_out_capture. Stimulus
//                pushes expected read data and flag states. A monitor pops
//                them and compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idft_out_capture;

    typedef struct {
        int          idx;
        logic [63:0] data;
    } rexp_t;

    typedef struct {
        bit          cf;
        logic        d;
        logic        b;
        logic        o;
        bit          cd;
        logic [63:0] data;
    } fexp_t;

    localparam logic [63:0] c_BASE_A = 64'hfa9e_04de_1000_0fc0;
    localparam logic [63:0] c_BASE_B = 64'hfa9e_04de_3000_2fc0;
    localparam logic [63:0] c_BASE_C = 64'h4444_3333_2222_1111;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   m_ovr    = 1'b0;
    bit   rd_seen  = 1'b0;

    rexp_t rq[$];
    fexp_t fq[$];

    idft_out_capture_if #(.DW(16), .BEATS(32)) bus ();

    idft_out_capture #(.DW(16), .BEATS(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Marks the edges at which a read was issued
    always @(posedge clk) rd_seen <= bus.rd_en_i;

    // Monitor: compares the DUT outputs between clock edges
    always @(negedge clk) begin
        rexp_t r;
        fexp_t f;
        if (rd_seen) begin
            n_checks++;
            if (rq.size() == 0) begin
                n_fail++;
                $display("FAIL rd_underflow: read seen with got %h but no expected entry", bus.rd_data_o);
            end else begin
                r = rq.pop_front();
                if (bus.rd_data_o !== r.data) begin
                    n_fail++;
                    $display("FAIL rd_data[%0d]: got %h expected %h", r.idx, bus.rd_data_o, r.data);
                end
            end
        end
        while (fq.size() > 0) begin
            f = fq.pop_front();
            if (f.cf) begin
                n_checks++;
                if ({bus.done_o, bus.busy_o, bus.overrun_o} !== {f.d, f.b, f.o}) begin
                    n_fail++;
                    $display("FAIL flags(done,busy,ovr) @%0t: got %b%b%b expected %b%b%b", $time,
                             bus.done_o, bus.busy_o, bus.overrun_o, f.d, f.b, f.o);
                end
            end
            if (f.cd) begin
                n_checks++;
                if (bus.rd_data_o !== f.data) begin
                    n_fail++;
                    $display("FAIL rd_data_hold @%0t: got %h expected %h", $time, bus.rd_data_o, f.data);
                end
            end
        end
    end

    function automatic logic [63:0] beat(input logic [63:0] base, input int j);
        logic [15:0] k;
        k = 16'(j);
        return {base[63:48] + k, base[47:32] + k, base[31:16] + k, base[15:0] + k};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_flags(input logic d, input logic b, input logic o,
                             input bit cd, input logic [63:0] data);
        fexp_t f;
        f.cf = 1'b1; f.d = d; f.b = b; f.o = o; f.cd = cd; f.data = data;
        fq.push_back(f);
    endtask

    task automatic exp_data(input logic [63:0] data);
        fexp_t f;
        f.cf = 1'b0; f.d = 1'b0; f.b = 1'b0; f.o = 1'b0; f.cd = 1'b1; f.data = data;
        fq.push_back(f);
    endtask

    task automatic issue_rd(input int idx, input logic [63:0] data);
        rexp_t r;
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 5'(idx);
        r.idx = idx; r.data = data;
        rq.push_back(r);
    endtask

    // One transform: strobe, then 32 beats. Optional extras: overrun strobe,
    // read-during-write, reset at a beat, and clear with the strobe or last beat.
    task automatic burst(input logic [63:0] base, input int ovr_beat,
                         input int rdw_beat, input logic [63:0] old_base,
                         input int rst_beat, input bit clr_start, input bit clr_last);
        bus.next_out_i = 1'b1;
        bus.clear_i    = clr_start;
        tick();
        bus.next_out_i = 1'b0;
        bus.clear_i    = 1'b0;
        if (clr_start) m_ovr = 1'b0;
        exp_flags(1'b0, 1'b1, m_ovr, 1'b0, '0);
        for (int j = 0; j < 32; j++) begin
            {bus.y3_i, bus.y2_i, bus.y1_i, bus.y0_i} = beat(base, j);
            if (j == ovr_beat) bus.next_out_i = 1'b1;
            if (j == rdw_beat) issue_rd(j, beat(old_base, j));
            if (rdw_beat >= 0 && j == rdw_beat + 1) issue_rd(j - 1, beat(base, j - 1));
            if (j == 31 && clr_last) bus.clear_i = 1'b1;
            if (j == rst_beat) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                m_ovr = 1'b0;
                exp_flags(1'b0, 1'b0, 1'b0, 1'b1, '0);
                return;
            end
            tick();
            bus.next_out_i = 1'b0;
            bus.rd_en_i    = 1'b0;
            bus.clear_i    = 1'b0;
            if (j == ovr_beat) m_ovr = 1'b1;
            if (j == 30) exp_flags(1'b0, 1'b1, m_ovr, 1'b0, '0);
        end
        exp_flags(1'b1, 1'b0, m_ovr, 1'b0, '0);
    endtask

    // Back-to-back reads of every index, then confirm the output holds
    task automatic read_all(input logic [63:0] base);
        for (int i = 0; i < 32; i++) begin
            issue_rd(i, beat(base, i));
            tick();
        end
        bus.rd_en_i = 1'b0;
        tick();
        tick();
        exp_data(beat(base, 31));
    endtask

    task automatic clear_pulse();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        m_ovr = 1'b0;
        exp_flags(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.next_out_i = 1'b0;
        bus.y0_i       = '0;
        bus.y1_i       = '0;
        bus.y2_i       = '0;
        bus.y3_i       = '0;
        bus.clear_i    = 1'b0;
        bus.rd_en_i    = 1'b0;
        bus.rd_idx_i   = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_flags(1'b0, 1'b0, 1'b0, 1'b1, '0);
        tick();

        // First transform and full readback
        burst(c_BASE_A, -1, -1, '0, -1, 1'b0, 1'b0);
        read_all(c_BASE_A);

        // Clear drops done, then a second transform overwrites every index
        clear_pulse();
        burst(c_BASE_B, -1, -1, '0, -1, 1'b0, 1'b0);
        read_all(c_BASE_B);

        // Extra strobe 10 cycles into a capture
        burst(c_BASE_A, 9, -1, '0, -1, 1'b0, 1'b0);
        read_all(c_BASE_A);
        clear_pulse();

        // Read idx 5 while beat 5 is written, then again on the next cycle
        burst(c_BASE_B, -1, 5, c_BASE_A, -1, 1'b0, 1'b0);
        read_all(c_BASE_B);

        // Reset at beat 15, idle check, then a fresh complete capture
        burst(c_BASE_C, -1, -1, '0, 15, 1'b0, 1'b0);
        tick();
        tick();
        exp_flags(1'b0, 1'b0, 1'b0, 1'b0, '0);
        burst(c_BASE_C, -1, -1, '0, -1, 1'b0, 1'b0);
        read_all(c_BASE_C);

        // Clear together with the strobe and together with the final beat
        burst(c_BASE_A, -1, -1, '0, -1, 1'b1, 1'b1);
        read_all(c_BASE_A);

        tick();
        tick();
        n_checks++;
        if (rq.size() != 0 || fq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending entries expected 0/0", rq.size(), fq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
